// File: rtl/saturn_fetch_pkg.sv
// Shared definitions for the Saturn instruction prefetcher: hp48 bus command codes
// and the fetch state encoding shown on decoder-side debug displays.
package saturn_fetch_pkg;

  localparam logic [3:0] BUSCMD_NOP         = 4'h0;
  localparam logic [3:0] BUSCMD_ID          = 4'h1;
  localparam logic [3:0] BUSCMD_PC_READ     = 4'h2;
  localparam logic [3:0] BUSCMD_DP_READ     = 4'h3;
  localparam logic [3:0] BUSCMD_PC_WRITE    = 4'h4;
  localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h7;
  localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h8;
  localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h9;
  localparam logic [3:0] BUSCMD_RESET       = 4'hF;

  typedef enum logic [1:0] {
    FETCH_LOAD   = 2'd0,
    FETCH_STREAM = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/saturn_nibble_fifo.sv
// Nibble queue with an address tag per entry; head is read straight from storage
// registers, so nothing from push/pop reaches the outputs combinationally.
module saturn_nibble_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [3:0]                 push_nibble,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic                       pop,
  output logic [3:0]                 head_nibble,
  output logic [ADDR_W-1:0]          head_pc,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [3:0]        nib_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     count;
  logic              do_pop;

  assign do_pop      = pop & ~empty;
  assign empty       = (count == '0);
  assign full        = (count == LW'(DEPTH));
  assign level       = count;
  assign head_nibble = nib_mem[rd_ptr];
  assign head_pc     = pc_mem[rd_ptr];

  // Clear only resets occupancy; stale entries are never visible while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        nib_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        nib_mem[wr_ptr] <= push_nibble;
        pc_mem[wr_ptr]  <= push_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/saturn_fetch_unit.sv
// Buffered instruction-nibble prefetcher: drives LOAD_PC/PC_READ on the hp48 bus
// and hands tagged nibbles to the decoder through a valid/ready port.
module saturn_fetch_unit
  import saturn_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_nibble,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       bus_strobe,
  output logic [3:0]                 bus_command,
  output logic [ADDR_W-1:0]          bus_address,
  input  logic [3:0]                 bus_nibble_rd,
  input  logic                       bus_error,
  output logic                       halt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output fetch_state_t               fetch_state
);

  localparam int LW = $clog2(DEPTH+1);

  // Decoder port: the head transfers on a rising edge where out_valid and out_ready
  // are both high; out_valid never depends on out_ready, and a redirect voids the pop.

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic [ADDR_W-1:0] resp_pc_q;
  logic              inflight_q, inflight_d;
  logic              strobe_d;
  logic [3:0]        command_d;
  logic [ADDR_W-1:0] address_d;

  logic              read_out;
  logic              resp_err;
  logic              redirect_take;
  logic              push;
  logic              pop;
  logic              room;
  logic [LW:0]       level_after;
  logic              fifo_full;
  logic              fifo_empty;

  assign out_valid   = ~fifo_empty;
  assign halt        = (state_q == FETCH_HALTED);
  assign fetch_state = state_q;
  // The read on the bus this cycle answers next cycle, so it already holds a slot.
  assign read_out    = bus_strobe & (bus_command == BUSCMD_PC_READ);

  always_comb begin
    resp_err      = inflight_q & bus_error;
    redirect_take = redirect_valid & (state_q != FETCH_HALTED) & ~resp_err;
    pop           = ~fifo_empty & out_ready & ~redirect_take;
    push          = inflight_q & ~bus_error & ~redirect_take & (~fifo_full | pop);
    level_after   = {1'b0, level} + {{LW{1'b0}}, push} - {{LW{1'b0}}, pop};
    room          = (level_after + {{LW{1'b0}}, read_out}) < (LW+1)'(DEPTH);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    strobe_d   = 1'b0;
    command_d  = BUSCMD_NOP;
    address_d  = '0;
    inflight_d = read_out & ~redirect_take & ~resp_err & (state_q != FETCH_HALTED);
    if (state_q == FETCH_HALTED || resp_err) begin
      state_d = FETCH_HALTED;
    end else if (redirect_take) begin
      state_d    = FETCH_STREAM;
      fetch_pc_d = redirect_pc;
      strobe_d   = 1'b1;
      command_d  = BUSCMD_LOAD_PC;
      address_d  = redirect_pc;
    end else begin
      case (state_q)
        FETCH_LOAD: begin
          state_d   = FETCH_STREAM;
          strobe_d  = 1'b1;
          command_d = BUSCMD_LOAD_PC;
          address_d = fetch_pc_q;
        end
        FETCH_STREAM: begin
          if (room) begin
            strobe_d   = 1'b1;
            command_d  = BUSCMD_PC_READ;
            issue_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH_LOAD;
      fetch_pc_q  <= RESET_PC;
      issue_pc_q  <= '0;
      resp_pc_q   <= '0;
      inflight_q  <= 1'b0;
      bus_strobe  <= 1'b0;
      bus_command <= BUSCMD_NOP;
      bus_address <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_pc_q  <= issue_pc_d;
      resp_pc_q   <= issue_pc_q;
      inflight_q  <= inflight_d;
      bus_strobe  <= strobe_d;
      bus_command <= command_d;
      bus_address <= address_d;
    end
  end

  saturn_nibble_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear       (redirect_take),
    .push        (push),
    .push_nibble (bus_nibble_rd),
    .push_pc     (resp_pc_q),
    .pop         (pop),
    .head_nibble (out_nibble),
    .head_pc     (out_pc),
    .level       (level),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

endmodule

// File: tb/tb_saturn_fetch_unit.sv
// Bench for saturn_fetch_unit: reset/redirect/wrap vector table, hand-written
// backpressure, in-flight redirect and bus-error sequences, then random traffic.
module tb_saturn_fetch_unit;
  import saturn_fetch_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] RESET_PC = 20'h00100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_nibble;
  logic [ADDR_W-1:0] out_pc;
  logic              bus_strobe;
  logic [3:0]        bus_command;
  logic [ADDR_W-1:0] bus_address;
  logic [3:0]        bus_nibble_rd = '0;
  logic              bus_error = 1'b0;
  logic              halt;
  logic [LW-1:0]     level;
  fetch_state_t      dbg_state;

  always #5 clk = ~clk;

  saturn_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_nibble(out_nibble), .out_pc(out_pc),
    .bus_strobe(bus_strobe), .bus_command(bus_command), .bus_address(bus_address),
    .bus_nibble_rd(bus_nibble_rd), .bus_error(bus_error), .halt(halt), .level(level),
    .fetch_state(dbg_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference: decoder-visible queue of {pc, nibble}, plus a simple bus with its own PC.
  logic [ADDR_W+3:0] exp_q[$];
  logic [ADDR_W-1:0] bus_pc, pend_tag, load_addr;
  logic              pend_valid, pend_drop, model_halt, expect_load;
  int                n_reads;

  typedef struct {
    logic              rdy;
    logic              rdir;
    logic [ADDR_W-1:0] rpc;
    logic              e_strobe;
    logic [3:0]        e_cmd;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
  } row_t;

  row_t tbl[15];

  function automatic logic [3:0] mem_nib(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[13:10] ^ a[19:16] ^ 4'hA;
  endfunction

  function automatic row_t mk(input logic rdy, input logic rdir, input logic [ADDR_W-1:0] rpc,
                              input logic es, input logic [3:0] ec, input logic [ADDR_W-1:0] ea,
                              input logic ev, input logic [ADDR_W-1:0] ep);
    row_t r;
    r.rdy = rdy; r.rdir = rdir; r.rpc = rpc; r.e_strobe = es; r.e_cmd = ec;
    r.e_addr = ea; r.e_valid = ev; r.e_pc = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    exp_q.delete();
    pend_valid  = 1'b0;
    pend_drop   = 1'b0;
    pend_tag    = '0;
    model_halt  = 1'b0;
    expect_load = 1'b1;
    load_addr   = RESET_PC;
    n_reads     = 0;
    bus_pc      = '0;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus_nibble_rd = '0; bus_error = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_nibble", 32'(out_nibble), 0);
    check("rst_out_pc", 32'(out_pc), 0);
    check("rst_bus_strobe", 32'(bus_strobe), 0);
    check("rst_bus_command", 32'(bus_command), 32'(BUSCMD_NOP));
    check("rst_bus_address", 32'(bus_address), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_level", 32'(level), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    @(negedge clk);
  endtask

  // One clock: score current outputs, act as bus, predict the next edge, drive inputs.
  task automatic tick(input logic rdy, input logic rdir, input logic [ADDR_W-1:0] rpc,
                      input logic berr);
    logic              resp_now, resp_drop, err, eff_r;
    logic [ADDR_W-1:0] resp_tag;
    check("level", 32'(level), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("head", 32'({out_pc, out_nibble}), 32'(exp_q[0]));
    check("halt", 32'(halt), 32'(model_halt));
    if (!bus_strobe) check("idle_nop", 32'(bus_command), 32'(BUSCMD_NOP));
    if (model_halt) check("halt_quiet", 32'(bus_strobe), 0);
    if (expect_load) begin
      check("load_cmd", 32'({bus_strobe, bus_command}), 32'({1'b1, BUSCMD_LOAD_PC}));
      check("load_addr", 32'(bus_address), 32'(load_addr));
    end else if (bus_strobe) begin
      check("stream_cmd", 32'(bus_command), 32'(BUSCMD_PC_READ));
    end

    resp_now  = pend_valid;
    resp_tag  = pend_tag;
    resp_drop = pend_drop;
    bus_nibble_rd = resp_now ? mem_nib(resp_tag) : 4'($urandom);
    bus_error     = resp_now && berr;
    err           = resp_now && !resp_drop && berr;
    pend_valid = 1'b0;
    pend_drop  = 1'b0;
    if (bus_strobe && bus_command == BUSCMD_LOAD_PC) begin
      bus_pc = bus_address;
    end else if (bus_strobe && bus_command == BUSCMD_PC_READ) begin
      pend_valid = 1'b1;
      pend_tag   = bus_pc;
      bus_pc     = bus_pc + 20'd1;
      n_reads++;
    end

    expect_load = 1'b0;
    eff_r = rdir && !model_halt && !err;
    if (err) begin
      model_halt = 1'b1;
      pend_drop  = 1'b1;
    end
    if (eff_r) begin
      exp_q.delete();
      pend_drop   = 1'b1;
      expect_load = 1'b1;
      load_addr   = rpc;
    end else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (resp_now && !resp_drop && !err) begin
        check("no_overflow", 32'(exp_q.size() < DEPTH), 1);
        exp_q.push_back({resp_tag, mem_nib(resp_tag)});
      end
    end

    out_ready      = rdy;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rdy_pct;
    logic rr, rd;
    logic [ADDR_W-1:0] rp;

    // Reset fetch, redirect timing and address wrap, cycle by cycle from reset release.
    tbl[0]  = mk(1, 0, 0,        1, BUSCMD_LOAD_PC, 20'h00100, 0, 0);
    tbl[1]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         0, 0);
    tbl[2]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         0, 0);
    tbl[3]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00100);
    tbl[4]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00101);
    tbl[5]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00102);
    tbl[6]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00103);
    tbl[7]  = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00104);
    tbl[8]  = mk(1, 1, 20'hFFFFE, 1, BUSCMD_PC_READ, 0,        1, 20'h00105);
    tbl[9]  = mk(1, 0, 0,        1, BUSCMD_LOAD_PC, 20'hFFFFE, 0, 0);
    tbl[10] = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         0, 0);
    tbl[11] = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         0, 0);
    tbl[12] = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'hFFFFE);
    tbl[13] = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'hFFFFF);
    tbl[14] = mk(1, 0, 0,        1, BUSCMD_PC_READ, 0,         1, 20'h00000);

    do_reset();
    for (int k = 0; k < 15; k++) begin
      check($sformatf("row%0d_strobe", k), 32'(bus_strobe), 32'(tbl[k].e_strobe));
      check($sformatf("row%0d_cmd", k), 32'(bus_command), 32'(tbl[k].e_cmd));
      if (tbl[k].e_cmd == BUSCMD_LOAD_PC)
        check($sformatf("row%0d_addr", k), 32'(bus_address), 32'(tbl[k].e_addr));
      check($sformatf("row%0d_valid", k), 32'(out_valid), 32'(tbl[k].e_valid));
      if (tbl[k].e_valid) begin
        check($sformatf("row%0d_pc", k), 32'(out_pc), 32'(tbl[k].e_pc));
        check($sformatf("row%0d_nib", k), 32'(out_nibble), 32'(mem_nib(tbl[k].e_pc)));
      end
      tick(tbl[k].rdy, tbl[k].rdir, tbl[k].rpc, 1'b0);
    end

    // Backpressure: exactly DEPTH reads, then one more per accepted nibble.
    do_reset();
    for (int i = 0; i < 14; i++) tick(0, 0, '0, 0);
    check("bp_reads", 32'(n_reads), 32'(DEPTH));
    check("bp_level_full", 32'(level), 32'(DEPTH));
    tick(1, 0, '0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, '0, 0);
    check("bp_one_more_read", 32'(n_reads), 32'(DEPTH + 1));
    check("bp_level_refill", 32'(level), 32'(DEPTH));

    // Redirect with five buffered and one read in flight; same-cycle pop voided.
    do_reset();
    for (int i = 0; i < 7; i++) tick(0, 0, '0, 0);
    check("rd_level5", 32'(level), 5);
    check("rd_read_in_flight", 32'(bus_command), 32'(BUSCMD_PC_READ));
    tick(1, 1, 20'h12345, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, '0, 0);
    check("rd_first_valid", 32'(out_valid), 1);
    check("rd_first_pc", 32'(out_pc), 32'(20'h12345));
    for (int i = 0; i < 6; i++) tick(1, 0, '0, 0);

    // Bus error on the third read.
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 0, '0, 0);
    tick(0, 0, '0, 1);
    check("err_halt", 32'(halt), 1);
    check("err_state", 32'(dbg_state), 32'(FETCH_HALTED));
    check("err_level", 32'(level), 2);
    check("err_head", 32'(out_pc), 32'(20'h00100));
    for (int i = 0; i < 4; i++) tick(1, 0, '0, 0);
    tick(0, 1, 20'h55555, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, '0, 0);
    check("err_redirect_ignored", 32'(bus_strobe), 0);
    check("err_still_halted", 32'(halt), 1);

    // Random traffic with redirects near the wrap point; reset mid-stream between phases.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(5, 100);
      if (i == 1500) do_reset();
      rr = ($urandom_range(1, 100) <= rdy_pct);
      rd = ($urandom_range(0, 39) == 0);
      rp = ($urandom_range(0, 2) == 0) ? (20'hFFFFF - 20'($urandom_range(0, 4))) : 20'($urandom);
      tick(rr, rd, rp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/saturn_fetch_unit.md
# saturn_fetch_unit

Parametrised instruction-nibble prefetcher between the Saturn core decoder and the `hp48_bus` controller. It replaces the single-nibble, strobe-per-decode fetch path with a buffered stream. It issues `BUSCMD_LOAD_PC` and `BUSCMD_PC_READ` autonomously and keeps up to `DEPTH` nibbles queued, each tagged with its address. The decoder consumes nibbles through a valid/ready handshake and redirects the stream on jumps.

## Interface
- `ADDR_W`, 20, address width (PC, bus address, tags)
- `DEPTH`, 8, FIFO depth in nibbles; power of two, ≥ 2
- `RESET_PC`, 0, fetch address after reset
- `clk` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `redirect_valid` input 1: discard the stream and restart fetching at `redirect_pc`.
- `redirect_pc` input `ADDR_W`: new fetch address.
- `out_valid` output 1: `out_nibble` and `out_pc` hold the FIFO head.
- `out_ready` input 1: decoder accepts the head this cycle.
- `out_nibble` output 4: instruction nibble.
- `out_pc` output `ADDR_W`: address of `out_nibble`.
- `bus_strobe` output 1: bus command valid this cycle.
- `bus_command` output 4: `BUSCMD_*` code.
- `bus_address` output `ADDR_W`: address for `LOAD_PC`.
- `bus_nibble_rd` input 4: read data, valid the cycle after a `PC_READ` strobe.
- `bus_error` input 1: sampled with read data.
- `halt` output 1: sticky bus error.
- `level` output `$clog2(DEPTH+1)`: FIFO occupancy.

## Operation
- States:
  - `LOAD`: issue `LOAD_PC` with `fetch_pc`, then go to `STREAM`.
  - `STREAM`: issue `PC_READ` whenever `level + inflight < DEPTH`.
  - `HALTED`: terminal until reset.
- `inflight` is 0 or 1 because bus latency is exactly 1. A `PC_READ` strobe at cycle N returns data at cycle N+1, which is written at the end of N+1. Back-to-back reads are allowed, one per cycle.
- `fetch_pc` increments by 1 per issued `PC_READ`, modulo 2^`ADDR_W`, so all-ones wraps to 0. The bus auto-increments its own PC identically. Each write tags the nibble with the `fetch_pc` value captured at issue.
- Pop happens when `out_valid & out_ready`. Push and pop in the same cycle leave `level` unchanged and are legal when full.
- Redirect at cycle N:
  - FIFO is cleared at the end of N.
  - Any response arriving at N+1 is dropped.
  - `fetch_pc` is set to `redirect_pc`.
  - State goes to `LOAD`.
  - A pop requested at N is ignored; redirect wins.
  - Redirect while in `LOAD` restarts `LOAD` with the newest address.
- Bus error:
  - `bus_error` high in a response cycle drops that nibble and enters `HALTED`.
  - `halt` goes high the next cycle.
  - No further strobes are issued.
  - Buffered nibbles still drain.
  - Redirects are ignored.
- `bus_strobe` low implies `bus_command` = `BUSCMD_NOP`.
- Reset mid-operation clears the FIFO, `inflight`, and `halt`. A response arriving after reset is ignored because `inflight` is 0.

## Timing
- Reset values:
  - `out_valid`=0, `out_nibble`=0, `out_pc`=0.
  - `bus_strobe`=0, `bus_command`=`BUSCMD_NOP`, `bus_address`=0.
  - `halt`=0, `level`=0.
  - State `LOAD`, `fetch_pc`=`RESET_PC`.
- After reset release (cycle 0 = first edge with reset low):
  - cycle 0: `LOAD_PC` strobe.
  - cycle 1: first `PC_READ`.
  - cycle 2: data returns.
  - cycle 3: `out_valid`=1.
- Redirect at N:
  - `out_valid`=0 from N+1.
  - N+1: `LOAD_PC` strobe.
  - N+2: `PC_READ`.
  - N+4: first new nibble valid.
- Steady state with `out_ready` held high: one nibble per cycle, no bubbles.
- FIFO outputs are registered. There is no combinational path from `out_ready` or `redirect_valid` to `bus_*` or `out_*`.

## Structure
- `BUSCMD_*` codes come from the shared `bus_commands.v`. The state encodings `FETCH_LOAD`, `FETCH_STREAM`, `FETCH_HALTED` go in a shared `fetch_states.v` for decoder-side debug display.
- One natural sub-module is `saturn_nibble_fifo`. It is parametrised by `DEPTH` and `ADDR_W` and provides push, pop, clear, data+tag storage, `level`, full and empty. The top-level block holds the state machine, `fetch_pc`, and `inflight`.

## Test plan
- **Reset fetch:** `RESET_PC`=0x00100, `out_ready`=1.
  - Strobes are `LOAD_PC` 0x00100 at cycle 0, then `PC_READ` every cycle.
  - Outputs start at cycle 3 with `out_pc` 0x00100, 0x00101, ….
- **Backpressure:** `out_ready`=0, `DEPTH`=8.
  - Exactly 8 `PC_READ` strobes, then none.
  - `level`=8.
  - Raising `out_ready` for 1 cycle triggers exactly one new read.
- **Redirect with a read in flight:** redirect to 0x12345 while FIFO holds 5.
  - The in-flight nibble is dropped.
  - `LOAD_PC` 0x12345 at N+1.
  - First output at N+4 has `out_pc`=0x12345.
  - A same-cycle pop does not alter the new stream.
- **Wrap:** redirect to 0xFFFFE.
  - `out_pc` sequence is 0xFFFFE, 0xFFFFF, 0x00000.
- **Bus error on the 3rd read:**
  - The 2 earlier nibbles still drain.
  - The 3rd is dropped.
  - `halt`=1 from the next cycle, then no strobes.
  - A later redirect is ignored.
  - Asserting `reset` clears `halt`.
- **Async reset mid-stream:** assert `reset` between edges.
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the cycle-0 `LOAD_PC` is issued with `RESET_PC`.
